// File: rtl/rvh_noc_pkg.sv
// =============================================================================
// Module   : rvh_noc_pkg
// Shared NoC router types: output-port id, VC count and VC id type.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package rvh_noc_pkg;

   typedef enum logic [2:0] {
      PORT_LOCAL = 3'd0,
      PORT_NORTH = 3'd1,
      PORT_EAST  = 3'd2,
      PORT_SOUTH = 3'd3,
      PORT_WEST  = 3'd4
   } io_port_t;

   localparam int VC_NUM  = 4;
   localparam int VC_ID_W = $clog2(VC_NUM);

   typedef logic [VC_ID_W-1:0] vc_id_t;

endpackage

`default_nettype wire

// File: rtl/noc_vc_fifo.sv
// =============================================================================
// Module   : noc_vc_fifo
// Single virtual-channel FIFO with count-based empty/full and wrap-at-depth pointers.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module noc_vc_fifo
   import rvh_noc_pkg::*;
#(
   parameter type ENTRY_T = logic [7:0],
   parameter int  DEPTH   = 2
)(
   input  logic   clk,
   input  logic   rstn,
   input  logic   push,
   input  logic   pop,
   input  ENTRY_T data_i,
   output ENTRY_T data_o,
   output logic   empty,
   output logic   full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   ENTRY_T             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_pop;
   logic               w_do_push;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (r_count == '0);
   assign full      = (r_count == CNT_W'(DEPTH));
   assign w_do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
   assign w_do_push = push && (!full || w_do_pop);
   assign data_o    = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/input_port_vc_buffer.sv
// =============================================================================
// Module   : input_port_vc_buffer
// Router input-port per-VC flit storage with head presentation and credit return.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module input_port_vc_buffer
   import rvh_noc_pkg::*;
#(
   parameter type flit_payload_t = logic [255:0],
   parameter int  VC_NUM         = 4,
   parameter int  VC_DEPTH       = 2,
   localparam int VC_ID_W        = $clog2(VC_NUM)
)(
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flit_v_i,
   input  flit_payload_t                flit_i,
   input  logic [VC_ID_W-1:0]           flit_vc_id_i,
   input  io_port_t                     flit_look_ahead_routing_i,
   input  logic [VC_NUM-1:0]            pop_i,
   output logic [VC_NUM-1:0]            head_v_o,
   output flit_payload_t [VC_NUM-1:0]   head_flit_o,
   output io_port_t [VC_NUM-1:0]        head_lar_o,
   output logic                         credit_v_o,
   output logic [VC_ID_W-1:0]           credit_vc_id_o
);

   typedef struct packed {
      io_port_t      lar;
      flit_payload_t flit;
   } entry_t;

   entry_t              w_wr_entry;
   logic                w_vc_ok;
   logic [VC_NUM-1:0]   w_push;
   logic [VC_NUM-1:0]   w_empty;
   logic [VC_NUM-1:0]   w_full;
   logic [VC_NUM-1:0]   w_pop_ok;
   logic                r_credit_v;
   logic [VC_ID_W-1:0]  r_credit_vc_id;

   function automatic logic [VC_ID_W-1:0] first_set(input logic [VC_NUM-1:0] vec);
      logic [VC_ID_W-1:0] idx;
      idx = '0;
      for (int i = VC_NUM - 1; i >= 0; i--) begin
         if (vec[i]) idx = VC_ID_W'(i);
      end
      return idx;
   endfunction

   assign w_wr_entry.lar  = flit_look_ahead_routing_i;
   assign w_wr_entry.flit = flit_i;
   assign w_vc_ok         = (32'(flit_vc_id_i) < VC_NUM);
   // Pops of empty VCs are ignored and must not produce a credit.
   assign w_pop_ok        = pop_i & ~w_empty;
   assign head_v_o        = ~w_empty;

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      entry_t w_head;

      assign w_push[v] = flit_v_i && w_vc_ok && (32'(flit_vc_id_i) == v);

      noc_vc_fifo #(
         .ENTRY_T (entry_t),
         .DEPTH   (VC_DEPTH)
      ) u_fifo (
         .clk    (clk),
         .rstn   (rstn),
         .push   (w_push[v]),
         .pop    (pop_i[v]),
         .data_i (w_wr_entry),
         .data_o (w_head),
         .empty  (w_empty[v]),
         .full   (w_full[v])
      );

      assign head_flit_o[v] = w_head.flit;
      assign head_lar_o[v]  = w_head.lar;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_credit_v     <= 1'b0;
         r_credit_vc_id <= '0;
      end else begin
         r_credit_v <= |w_pop_ok;
         if (|w_pop_ok) r_credit_vc_id <= first_set(w_pop_ok);
      end
   end

   assign credit_v_o     = r_credit_v;
   assign credit_vc_id_o = r_credit_vc_id;

   always_ff @(posedge clk) begin
      if (rstn) begin
         assert ($onehot0(pop_i))
            else $warning("%m: pop_i not one-hot0 (%b)", pop_i);
         assert ((pop_i & w_empty) == '0)
            else $warning("%m: pop of empty VC ignored (pop=%b)", pop_i);
         assert ((w_push & w_full & ~w_pop_ok) == '0)
            else $warning("%m: push to full VC %0d dropped", flit_vc_id_i);
         assert (!(flit_v_i && !w_vc_ok))
            else $warning("%m: push to out-of-range VC %0d dropped", flit_vc_id_i);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_input_port_vc_buffer.sv
// =============================================================================
// Module   : tb_input_port_vc_buffer
// Directed and randomized checks of input_port_vc_buffer at VC_DEPTH 2, 1 and 3.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_input_port_vc_buffer;
   import rvh_noc_pkg::*;

   typedef logic [255:0] flit_t;
   typedef struct packed {
      io_port_t lar;
      flit_t    flit;
   } ent_t;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rstn;
   logic       flit_v;
   flit_t      flit;
   vc_id_t     vc;
   io_port_t   lar;
   logic [3:0] pop;

   logic [3:0]        hv  [NI];
   logic [3:0][255:0] hf  [NI];
   io_port_t [3:0]    hl  [NI];
   logic              cv  [NI];
   vc_id_t            cid [NI];

   ent_t mq [NI*4][$];
   logic ecv  [NI];
   int   ecid [NI];
   int   model_pops [NI];
   int   dut_creds  [NI];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   input_port_vc_buffer #(.VC_NUM(4), .VC_DEPTH(2)) u_dut_d2 (
      .clk(clk), .rstn(rstn), .flit_v_i(flit_v), .flit_i(flit), .flit_vc_id_i(vc),
      .flit_look_ahead_routing_i(lar), .pop_i(pop), .head_v_o(hv[0]), .head_flit_o(hf[0]),
      .head_lar_o(hl[0]), .credit_v_o(cv[0]), .credit_vc_id_o(cid[0]));

   input_port_vc_buffer #(.VC_NUM(4), .VC_DEPTH(1)) u_dut_d1 (
      .clk(clk), .rstn(rstn), .flit_v_i(flit_v), .flit_i(flit), .flit_vc_id_i(vc),
      .flit_look_ahead_routing_i(lar), .pop_i(pop), .head_v_o(hv[1]), .head_flit_o(hf[1]),
      .head_lar_o(hl[1]), .credit_v_o(cv[1]), .credit_vc_id_o(cid[1]));

   input_port_vc_buffer #(.VC_NUM(4), .VC_DEPTH(3)) u_dut_d3 (
      .clk(clk), .rstn(rstn), .flit_v_i(flit_v), .flit_i(flit), .flit_vc_id_i(vc),
      .flit_look_ahead_routing_i(lar), .pop_i(pop), .head_v_o(hv[2]), .head_flit_o(hf[2]),
      .head_lar_o(hl[2]), .credit_v_o(cv[2]), .credit_vc_id_o(cid[2]));

   function automatic int depth_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic flit_t rand_flit();
      flit_t x;
      for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom();
      return x;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: per-VC queues; a pop (if the VC holds data) is taken first,
   // then a push is accepted whenever the VC has room afterwards.
   task automatic model_update();
      for (int k = 0; k < NI; k++) begin
         if (!rstn) begin
            for (int v = 0; v < 4; v++) mq[k*4+v].delete();
            ecv[k]  = 1'b0;
            ecid[k] = 0;
         end else begin
            int popped;
            popped = -1;
            for (int v = 0; v < 4; v++)
               if (pop[v] && mq[k*4+v].size() != 0) popped = v;
            if (popped >= 0) begin
               void'(mq[k*4+popped].pop_front());
               model_pops[k]++;
               ecid[k] = popped;
            end
            ecv[k] = (popped >= 0);
            if (flit_v && mq[k*4+int'(vc)].size() < depth_of(k))
               mq[k*4+int'(vc)].push_back('{lar: lar, flit: flit});
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         logic [3:0] mask;
         for (int v = 0; v < 4; v++) mask[v] = (mq[k*4+v].size() != 0);
         chk($sformatf("k%0d head_v", k), 256'(hv[k]), 256'(mask));
         chk($sformatf("k%0d credit_v", k), 256'(cv[k]), 256'(ecv[k]));
         if (ecv[k]) chk($sformatf("k%0d credit_vc_id", k), 256'(cid[k]), 256'(ecid[k]));
         if (cv[k]) dut_creds[k]++;
         for (int v = 0; v < 4; v++) begin
            if (mask[v]) begin
               chk($sformatf("k%0d vc%0d head_flit", k, v), hf[k][v], mq[k*4+v][0].flit);
               chk($sformatf("k%0d vc%0d head_lar", k, v), 256'(hl[k][v]), 256'(mq[k*4+v][0].lar));
            end
         end
      end
   endtask

   task automatic cyc();
      model_update();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      flit_v = 1'b0;
      pop    = 4'b0000;
   endtask

   task automatic set_push(input int v, input flit_t f, input int port);
      flit_v = 1'b1;
      vc     = vc_id_t'(v);
      flit   = f;
      lar    = io_port_t'(port);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         model_pops[k] = 0;
         dut_creds[k]  = 0;
         ecv[k]        = 1'b0;
         ecid[k]       = 0;
      end
      rstn = 1'b0;
      flit = '0;
      vc   = '0;
      lar  = PORT_LOCAL;
      idle();
      cyc();
      cyc();
      chk("rst head_v", 256'(hv[0]), 256'(4'b0000));
      chk("rst credit_v", 256'(cv[0]), 256'(1'b0));
      chk("rst credit_vc_id", 256'(cid[0]), 256'(2'd0));
      rstn = 1'b1;

      // 1: single push to VC1, visible next cycle
      set_push(1, 256'hA5, 2);
      cyc();
      idle();
      chk("t1 head_v", 256'(hv[0]), 256'(4'b0010));
      chk("t1 head_lar", 256'(hl[0][1]), 256'(3'd2));
      chk("t1 head_flit", hf[0][1], 256'hA5);
      chk("t1 credit_v", 256'(cv[0]), 256'(1'b0));
      pop = 4'b0010;
      cyc();
      idle();
      chk("t1 pop credit_vc_id", 256'(cid[0]), 256'(2'd1));

      // 2: fill VC0 then drain in order
      set_push(0, 256'h1, 1);
      cyc();
      set_push(0, 256'h2, 3);
      cyc();
      idle();
      chk("t2 head0", hf[0][0], 256'h1);
      pop = 4'b0001;
      cyc();
      chk("t2 credit_v a", 256'(cv[0]), 256'(1'b1));
      chk("t2 credit_vc_id a", 256'(cid[0]), 256'(2'd0));
      chk("t2 head1", hf[0][0], 256'h2);
      cyc();
      idle();
      chk("t2 credit_v b", 256'(cv[0]), 256'(1'b1));
      chk("t2 empty", 256'(hv[0]), 256'(4'b0000));
      cyc();
      chk("t2 credit drop", 256'(cv[0]), 256'(1'b0));

      // 3: full VC2, push and pop together
      set_push(2, 256'h11, 4);
      cyc();
      set_push(2, 256'h22, 0);
      cyc();
      set_push(2, 256'h3, 2);
      pop = 4'b0100;
      cyc();
      idle();
      chk("t3 head after swap", hf[0][2], 256'h22);
      chk("t3 still full", 256'(hv[0][2]), 256'(1'b1));
      chk("t3 credit_vc_id", 256'(cid[0]), 256'(2'd2));
      pop = 4'b0100;
      cyc();
      chk("t3 head 0x3", hf[0][2], 256'h3);
      cyc();
      idle();
      chk("t3 drained", 256'(hv[0]), 256'(4'b0000));

      // 4: push into full VC3 with no pop is dropped
      set_push(3, 256'h7, 1);
      cyc();
      set_push(3, 256'h8, 1);
      cyc();
      set_push(3, 256'h9, 1);
      cyc();
      idle();
      chk("t4 head kept", hf[0][3], 256'h7);
      pop = 4'b1000;
      cyc();
      chk("t4 second head", hf[0][3], 256'h8);
      cyc();
      idle();
      chk("t4 empty", 256'(hv[0]), 256'(4'b0000));
      cyc();

      // 5: pop of empty VC1
      pop = 4'b0010;
      cyc();
      idle();
      chk("t5 no credit", 256'(cv[0]), 256'(1'b0));
      chk("t5 still empty", 256'(hv[0]), 256'(4'b0000));

      // 6: reset while loaded and popping
      set_push(0, 256'hB0, 1);
      cyc();
      set_push(1, 256'hB1, 2);
      cyc();
      set_push(2, 256'hB2, 3);
      cyc();
      idle();
      pop  = 4'b0001;
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      idle();
      chk("t6 head_v cleared", 256'(hv[0]), 256'(4'b0000));
      chk("t6 credit cancelled", 256'(cv[0]), 256'(1'b0));
      set_push(2, 256'h55, 4);
      cyc();
      idle();
      chk("t6 fresh head_v", 256'(hv[0]), 256'(4'b0100));
      chk("t6 fresh flit", hf[0][2], 256'h55);
      pop = 4'b0100;
      cyc();
      idle();
      cyc();

      // Random: legal traffic for every depth, checked cycle by cycle against the queues
      for (int k = 0; k < NI; k++) begin
         model_pops[k] = 0;
         dut_creds[k]  = 0;
      end
      for (int n = 0; n < 800; n++) begin
         int  p;
         int  s;
         bit  ok;
         idle();
         if ($urandom_range(0, 9) < 6) begin
            p  = int'($urandom_range(0, 3));
            ok = 1'b1;
            for (int k = 0; k < NI; k++) if (mq[k*4+p].size() == 0) ok = 1'b0;
            if (ok) pop[p] = 1'b1;
         end
         if ($urandom_range(0, 9) < 7) begin
            s  = int'($urandom_range(0, 3));
            ok = 1'b1;
            for (int k = 0; k < NI; k++)
               if (mq[k*4+s].size() - (pop[s] ? 1 : 0) >= depth_of(k)) ok = 1'b0;
            if (ok) set_push(s, rand_flit(), int'($urandom_range(0, 4)));
         end
         cyc();
      end
      idle();
      cyc();
      cyc();
      for (int k = 0; k < NI; k++)
         chk($sformatf("k%0d credit total", k), 256'(dut_creds[k]), 256'(model_pops[k]));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
